// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - sequential radix-4 Booth recoder and partial-product accumulator
// Issues one Booth triplet per cycle and sums the generator's registered pp words.
module booth_seq_ctrl #(
  parameter int A_W  = 8,
  parameter int ROWS = 4,
  parameter int P_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [A_W-1:0]    a,
  output logic              ready,
  output logic [2:0]        opr,
  output logic [1:0]        extend_one,
  input  logic [14:0]       pp,
  output logic              done,
  output logic [P_W-1:0]    product
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

  state_t         state_q, state_d;
  logic [A_W-1:0] a_q, a_d;
  logic [1:0]     row_q, row_d;
  logic [P_W-1:0] acc_q, acc_d;
  logic [P_W-1:0] prod_q, prod_d;
  logic           vld_q, vld_d;

  logic           issuing;
  logic [A_W:0]   a_ext;
  logic [P_W-1:0] pp_ext;
  logic [P_W-1:0] acc_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      vld_q   <= vld_d;
    end
  end

  // a_ext carries the implicit a[-1]=0 below the operand so row r reads bits [2r+2:2r].
  always_comb begin
    issuing = (state_q == ISSUE);
    a_ext   = {a_q, 1'b0};
    pp_ext  = {{(P_W-15){pp[14]}}, pp};
    acc_sum = acc_q + pp_ext;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    row_d      = row_q;
    acc_d      = vld_q ? acc_sum : acc_q;
    prod_d     = prod_q;
    vld_d      = issuing;
    ready      = (state_q == IDLE);
    done       = (state_q == DONE);
    opr        = 3'b000;
    extend_one = 2'b00;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          acc_d   = '0;
          row_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        opr        = a_ext[{row_q, 1'b0} +: 3];
        extend_one = row_q;
        row_d      = row_q + 2'd1;
        if (row_q == LAST_ROW) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last row's pp arrives this cycle; fold it straight into the product.
        prod_d  = acc_sum;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign product = prod_q;

endmodule
